// File: rtl/bram_capture_ctrl.sv
// Triggered snapshot controller: arms on request, waits for a trigger, then writes
// a decimated window of the DSP sample stream into the host capture BRAM.
module bram_capture_ctrl #(
    parameter int ADDRWIDTH = 13,
    parameter int DATAWIDTH = 64,
    parameter int DECWIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trig,
    input  logic                   force_trig,
    input  logic                   din_valid,
    input  logic [DATAWIDTH-1:0]   din,
    input  logic [ADDRWIDTH:0]     len,
    input  logic [DECWIDTH-1:0]    decim,
    output logic [ADDRWIDTH-1:0]   bram_addr,
    output logic [DATAWIDTH/8-1:0] bram_we,
    output logic [DATAWIDTH-1:0]   bram_data,
    output logic                   busy,
    output logic                   armed,
    output logic                   done,
    output logic [ADDRWIDTH:0]     wr_count
);

    localparam int CNTWIDTH = ADDRWIDTH + 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t              state, state_next;
    logic [CNTWIDTH-1:0] len_q;
    logic [DECWIDTH-1:0] decim_q;
    logic [DECWIDTH-1:0] dec_cnt, dec_next;
    logic                trig_hit;
    logic                accept;
    logic                last_write;

    assign trig_hit = trig | force_trig;

    // busy/armed are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            armed <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            busy  <= (state_next == ARMED) || (state_next == CAPTURE);
            armed <= (state_next == ARMED);
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else if (arm) begin
            state_next = ARMED;
        end else begin
            case (state)
                ARMED:   if (trig_hit) state_next = last_write ? DONE : CAPTURE;
                CAPTURE: if (last_write) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    // The trigger cycle behaves like a capture cycle with the decimation counter at zero.
    always_comb begin
        accept   = 1'b0;
        dec_next = dec_cnt;
        case (state)
            ARMED: begin
                if (trig_hit) begin
                    accept   = din_valid;
                    dec_next = din_valid ? decim_q : '0;
                end
            end
            CAPTURE: begin
                if (din_valid) begin
                    accept   = (dec_cnt == '0);
                    dec_next = (dec_cnt == '0) ? decim_q : dec_cnt - DECWIDTH'(1);
                end
            end
            default: begin
                accept   = 1'b0;
                dec_next = dec_cnt;
            end
        endcase
        if (abort || arm) accept = 1'b0;
        last_write = accept && ((wr_count + CNTWIDTH'(1)) == len_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            decim_q   <= '0;
            dec_cnt   <= '0;
            wr_count  <= '0;
            done      <= 1'b0;
            bram_addr <= '0;
            bram_we   <= '0;
            bram_data <= '0;
        end else begin
            bram_we <= '0;
            if (abort) begin
                dec_cnt <= '0;
            end else if (arm) begin
                len_q    <= (len == '0) ? (CNTWIDTH'(1) << ADDRWIDTH) : len;
                decim_q  <= decim;
                dec_cnt  <= '0;
                wr_count <= '0;
                done     <= 1'b0;
            end else begin
                dec_cnt <= dec_next;
                if (accept) begin
                    bram_we   <= '1;
                    bram_addr <= wr_count[ADDRWIDTH-1:0];
                    bram_data <= din;
                    wr_count  <= wr_count + CNTWIDTH'(1);
                    if (last_write) done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/bram_capture_ctrl.md
Name: bram_capture_ctrl

Overview:
- Triggered snapshot controller that writes one DSP sample stream (ADC word, counter pattern or cordic output) into the to-host capture BRAM.
- Sits directly downstream of the DSP source mux. It replaces the free-running address/write-enable counter with arm/trigger/length/decimation control, and feeds the BRAM port (addr/we/data) that the host reads.

Parameters:
ADDRWIDTH, 13, BRAM word address width
DATAWIDTH, 64, sample/BRAM word width (multiple of 8)
DECWIDTH, 8, width of decimation control

Ports:
clk  in  1  DSP clock
reset  in  1  asynchronous, active-high reset
arm  in  1  single-cycle pulse; latches len/decim, clears done, enters ARMED
abort  in  1  level; forces IDLE, stops writes
trig  in  1  level trigger qualifier (external/sequencer)
force_trig  in  1  software trigger pulse
din_valid  in  1  sample qualifier for din
din  in  DATAWIDTH  sample word from DSP source mux
len  in  ADDRWIDTH+1  words to capture; 0 means 2^ADDRWIDTH
decim  in  DECWIDTH  store 1 of every decim+1 valid samples
bram_addr  out  ADDRWIDTH  BRAM write address
bram_we  out  DATAWIDTH/8  byte write enables (all-equal)
bram_data  out  DATAWIDTH  BRAM write data
busy  out  1  high in ARMED or CAPTURE
armed  out  1  high in ARMED
done  out  1  sticky capture-complete flag
wr_count  out  ADDRWIDTH+1  words written in current/last capture

Behaviour:
- Reset (async assert, sync release): state IDLE; bram_addr=0, bram_we=0, bram_data=0, busy=0, armed=0, done=0, wr_count=0; internal decim counter=0.
- Priority each cycle: reset > abort > arm > state action.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE/DONE + arm:
  - latch len (0 -> 2^ADDRWIDTH) and decim
  - clear done and wr_count
  - go to ARMED next cycle
- ARMED:
  - Trigger condition = trig | force_trig, sampled from the cycle after arm onward. A trigger coincident with the arm pulse is ignored.
  - On trigger: go to CAPTURE, clear decim counter. The sample present in the trigger cycle is the first candidate.
- CAPTURE, per cycle with din_valid=1:
  - If decim counter==0: write the sample and reload the counter to the latched decim.
  - Otherwise: decrement the counter, no write.
  - din_valid=0 cycles are neither counted nor written.
- Write pipeline:
  - A write accepted in cycle n presents bram_data=din(n), bram_addr=wr_count(n)[ADDRWIDTH-1:0] and bram_we=all-ones in cycle n+1. This is one register stage.
  - wr_count increments in the same edge.
  - bram_we=0 in every non-write cycle; bram_addr and bram_data hold their last values.
- Termination:
  - When the write making wr_count==len is accepted, the state goes to DONE in the same edge, and done=1 from that edge.
  - No further writes occur.
  - The final bram_we pulse still appears (cycle n+1).
- Address range: addresses 0..len-1, never wraps. For len=2^ADDRWIDTH the last address is all-ones; wr_count reaches 2^ADDRWIDTH without overflow.
- arm during ARMED or CAPTURE: restarts (re-latch, wr_count=0, back to ARMED). Writes already issued are not retracted.
- abort: any state -> IDLE next edge. bram_we=0 from the next cycle; a write accepted in the same cycle as abort is discarded. done is unchanged; wr_count holds.
- decim=0 stores every valid sample.
- len/decim changes outside the arm pulse have no effect on a capture in progress.
- busy = ARMED|CAPTURE; armed = ARMED. Both are registered outputs.

Test Plan:
- Reset mid-capture: reset asserted at word 5 -> all outputs 0 immediately (async); state IDLE after release.
- Basic capture: arm, len=4, decim=0, trig high 3 cycles later, din=counter 100,101,... all valid -> we pulses at addr 0..3 with data 100..103 on consecutive cycles, starting one cycle after trigger; done=1 with the last write edge; wr_count=4; no 5th write.
- Decimation and gaps: len=3, decim=2, din_valid toggling 1,0,1,1,0,1,1,1… with din=index -> only every 3rd valid sample is stored (valid samples #0, #3, #6) at addr 0,1,2.
- Trigger edge cases: trig held high during the arm pulse -> no capture that cycle, capture starts the following cycle. force_trig alone (trig=0) also starts a capture.
- Full depth: len=0 -> exactly 8192 writes at addr 0..8191, done=1, wr_count=8192, bram_addr never wraps to 0.
- Abort/re-arm: abort at wr_count=2 of len=8 -> IDLE, we low next cycle, done=0, wr_count=2. A new arm clears wr_count to 0, and the next capture starts at addr 0.
